// File: rtl/sysbus_pkg.sv
// Shared types and helpers for the data-side system bus router.
package sysbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = a[0];
         F3_W:        mis = (a != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/sysbus_router_decode.sv
// Region decoder: priority-encodes the address against the base/mask table,
// lowest index wins.
module sysbus_router_decode
   import sysbus_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NSLV = 4,
   parameter logic [NSLV-1:0][XLEN-1:0] REGION_BASE = '0,
   parameter logic [NSLV-1:0][XLEN-1:0] REGION_MASK = '0
) (
   input  logic [XLEN-1:0] addr_i,
   output logic [NSLV-1:0] hit_o,
   output logic            any_hit_o
);

   always_comb begin
      hit_o     = '0;
      any_hit_o = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (!any_hit_o && ((addr_i & REGION_MASK[i]) == REGION_BASE[i])) begin
            hit_o[i]  = 1'b1;
            any_hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sysbus_router.sv
// Data-side system bus: address decode, one-cycle slave strobe, wait for
// single- or multi-cycle slave, done/ack handshake with fault reporting.
//
// state | meaning
// IDLE  | waiting for init with re or wr
// REQ   | strobe selected slave, or report a decode/alignment fault
// WAIT  | waiting for slave data, ready or timeout
// DONE  | result presented, held until ack
module sysbus_router
   import sysbus_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NSLV = 4,
   parameter logic [NSLV-1:0][XLEN-1:0] REGION_BASE = '0,
   parameter logic [NSLV-1:0][XLEN-1:0] REGION_MASK = '0,
   parameter logic [NSLV-1:0] SINGLE_CYCLE = '1,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init,
   input  logic [XLEN-1:0]      base,
   input  logic [XLEN-1:0]      off,
   input  logic                 re,
   input  logic                 wr,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      wdata,
   input  logic                 ack,
   output logic                 done,
   output logic                 err,
   output logic [XLEN-1:0]      rdata,
   output logic [NSLV-1:0]      s_sel,
   output logic                 s_re,
   output logic                 s_wr,
   output logic [XLEN-1:0]      s_addr,
   output logic [XLEN-1:0]      s_wdata,
   output logic [2:0]           s_funct3,
   input  logic [NSLV*XLEN-1:0] s_rdata,
   input  logic [NSLV-1:0]      s_ready
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t              state_q;
   logic                done_q, err_q;
   logic [XLEN-1:0]     rdata_q;
   logic [NSLV-1:0]     s_sel_q;
   logic                s_re_q, s_wr_q;
   logic [XLEN-1:0]     s_addr_q, s_wdata_q;
   logic [2:0]          s_funct3_q;
   logic [NSLV-1:0]     slv_q;
   logic                op_wr_q;
   logic                bad_q;
   logic [CW-1:0]       cnt_q;

   logic [XLEN-1:0]     addr_d;
   logic [NSLV-1:0]     hit;
   logic                any_hit;
   logic                bad_d;
   logic [XLEN-1:0]     slv_rdata;
   logic                slv_single;
   logic                slv_ready;

   assign addr_d = base + off;

   sysbus_router_decode #(
      .XLEN        (XLEN),
      .NSLV        (NSLV),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK)
   ) u_decode (
      .addr_i    (addr_d),
      .hit_o     (hit),
      .any_hit_o (any_hit)
   );

   // Fault is resolved at request capture so REQ can drive registered strobes.
   assign bad_d = (re & wr) | is_misaligned(funct3, addr_d[1:0]) | ~any_hit;

   always_comb begin
      slv_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (slv_q[i]) begin
            slv_rdata = slv_rdata | s_rdata[i*XLEN +: XLEN];
         end
      end
   end

   assign slv_single = |(slv_q & SINGLE_CYCLE);
   assign slv_ready  = |(slv_q & s_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         s_sel_q    <= '0;
         s_re_q     <= 1'b0;
         s_wr_q     <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_funct3_q <= '0;
         slv_q      <= '0;
         op_wr_q    <= 1'b0;
         bad_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (init && (re || wr)) begin
                  s_addr_q   <= addr_d;
                  s_wdata_q  <= wdata;
                  s_funct3_q <= funct3;
                  op_wr_q    <= wr;
                  bad_q      <= bad_d;
                  slv_q      <= bad_d ? '0 : hit;
                  s_sel_q    <= bad_d ? '0 : hit;
                  s_re_q     <= ~bad_d & re;
                  s_wr_q     <= ~bad_d & wr;
                  state_q    <= REQ;
               end
            end
            REQ: begin
               s_sel_q <= '0;
               s_re_q  <= 1'b0;
               s_wr_q  <= 1'b0;
               if (bad_q) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (slv_single || slv_ready) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
                  rdata_q <= op_wr_q ? '0 : slv_rdata;
                  state_q <= DONE;
               end else if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (ack) begin
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done     = done_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign s_sel    = s_sel_q;
   assign s_re     = s_re_q;
   assign s_wr     = s_wr_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign s_funct3 = s_funct3_q;

endmodule

// File: tb/tb_sysbus_router.sv
// Scoreboard bench for sysbus_router: RAM/ROM/peripheral single-cycle slaves
// plus one multi-cycle slave at 0x4000_0000 with a programmable ready delay.
module tb_sysbus_router;

   localparam int XLEN = 32;
   localparam int NSLV = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init = 1'b0;
   logic [31:0] base = '0;
   logic [31:0] off = '0;
   logic re = 1'b0;
   logic wr = 1'b0;
   logic [2:0] funct3 = '0;
   logic [31:0] wdata = '0;
   logic ack = 1'b0;
   logic done, err;
   logic [31:0] rdata;
   logic [3:0] s_sel;
   logic s_re, s_wr;
   logic [31:0] s_addr, s_wdata;
   logic [2:0] s_funct3;
   logic [127:0] s_rdata;
   logic [3:0] s_ready;
   logic mc_ready = 1'b0;

   localparam logic [31:0] RAM_D = 32'hDEADBEEF;
   localparam logic [31:0] ROM_D = 32'hC0DE1234;
   localparam logic [31:0] PER_D = 32'hA5A5A5A5;
   localparam logic [31:0] MC_D  = 32'h12345678;

   assign s_rdata = {MC_D, PER_D, ROM_D, RAM_D};
   assign s_ready = {mc_ready, 3'b000};

   sysbus_router #(
      .XLEN         (XLEN),
      .NSLV         (NSLV),
      .REGION_BASE  ({32'h40000000, 32'h10000000, 32'h08000000, 32'h00000000}),
      .REGION_MASK  ({32'hF0000000, 32'hF0000000, 32'hF8000000, 32'hFC000000}),
      .SINGLE_CYCLE (4'b0111),
      .TIMEOUT      (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (init),
      .base     (base),
      .off      (off),
      .re       (re),
      .wr       (wr),
      .funct3   (funct3),
      .wdata    (wdata),
      .ack      (ack),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .s_sel    (s_sel),
      .s_re     (s_re),
      .s_wr     (s_wr),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_funct3 (s_funct3),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  sel;
      logic        re;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          lat;
      int          issue;
   } exp_t;

   exp_t sb[$];

   // multi-cycle slave: ready pulses mc_dly cycles after its strobe (0 = never)
   int mc_dly = 0;
   int mc_cnt = 0;
   always @(negedge clk) begin
      mc_ready = 1'b0;
      if (mc_cnt > 0) begin
         mc_cnt--;
         if (mc_cnt == 0) mc_ready = 1'b1;
      end
      if (rst_n && s_sel[3] && (s_re || s_wr) && mc_dly > 0) mc_cnt = mc_dly;
   end

   // monitor: records strobes, pops and checks on each rising done
   int n_strb = 0;
   logic [3:0] st_sel;
   logic st_re, st_wr;
   logic [31:0] st_addr, st_wdata;
   logic [2:0] st_f3;
   int st_cyc = 0;
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         n_strb = 0;
         done_prev = 1'b0;
      end else begin
         if (s_re || s_wr) begin
            n_strb++;
            st_sel = s_sel; st_re = s_re; st_wr = s_wr;
            st_addr = s_addr; st_wdata = s_wdata; st_f3 = s_funct3;
            st_cyc = cyc;
         end
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_latency", 32'(cyc - e.issue), 32'(e.lat));
               chk("err", 32'(err), 32'(e.err));
               chk("rdata", rdata, e.rdata);
               if (e.sel != 4'b0000) begin
                  chk("strobe_count", 32'(n_strb), 32'd1);
                  chk("strobe_cycle", 32'(st_cyc - e.issue), 32'd1);
                  chk("s_sel", 32'(st_sel), 32'(e.sel));
                  chk("s_re_s_wr", 32'({st_re, st_wr}), 32'({e.re, e.wr}));
                  chk("s_addr", st_addr, e.addr);
                  chk("s_funct3", 32'(st_f3), 32'(e.f3));
                  if (e.wr) chk("s_wdata", st_wdata, e.wdata);
               end else begin
                  chk("no_strobe", 32'(n_strb), 32'd0);
               end
            end
            n_strb = 0;
         end
         done_prev = done;
      end
   end

   task automatic issue(input logic [31:0] b, input logic [31:0] o, input logic r, input logic w,
                        input logic [2:0] f3, input logic [31:0] wd);
      @(posedge clk); #1;
      base = b; off = o; re = r; wr = w; funct3 = f3; wdata = wd; init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0; re = 1'b0; wr = 1'b0;
      base = 32'hFFFFFFFF; off = 32'hFFFFFFFF; wdata = 32'h0; funct3 = 3'b111;
   endtask

   task automatic run(input logic [31:0] b, input logic [31:0] o, input logic r, input logic w,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd, input logic [3:0] e_sel,
                      input int lat, input int dly, input logic init_on_ack);
      exp_t e;
      int k;
      mc_dly = dly;
      e.err = e_err; e.rdata = e_rd; e.sel = e_sel; e.re = r; e.wr = w;
      e.addr = b + o; e.wdata = wd; e.f3 = f3; e.lat = lat;
      e.issue = cyc + 1;
      sb.push_back(e);
      issue(b, o, r, w, f3, wd);
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (!done) begin
         chk("done_wait_timeout", 32'(done), 32'd1);
         return;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("done_hold", 32'({done, err}), 32'({1'b1, e_err}));
      ack = 1'b1;
      if (init_on_ack) begin
         init = 1'b1; re = 1'b1; base = 32'h0; off = 32'h0; funct3 = 3'b010;
      end
      @(posedge clk); #1;
      ack = 1'b0; init = 1'b0; re = 1'b0;
      chk("done_clear", 32'({done, err}), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("idle_quiet", 32'({s_re, s_wr, s_sel, done}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      #12;
      chk("reset_outputs", 32'({done, err, s_sel, s_re, s_wr, s_funct3}), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_s_addr", s_addr, 32'd0);
      chk("reset_s_wdata", s_wdata, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      //   base          off           re    wr    f3      wdata         err   rdata        sel      lat dly ack+init
      run(32'h00000100, 32'h00000004, 1'b1, 1'b0, 3'b010, 32'h0,        1'b0, RAM_D,       4'b0001, 3, 0, 1'b0);
      run(32'h00000000, 32'h0FFFFFFF, 1'b1, 1'b0, 3'b100, 32'h0,        1'b0, ROM_D,       4'b0010, 3, 0, 1'b0);
      run(32'h10000000, 32'h00000008, 1'b0, 1'b1, 3'b010, 32'h00000055, 1'b0, 32'h0,       4'b0100, 3, 0, 1'b0);
      run(32'h10000000, 32'h00000002, 1'b0, 1'b1, 3'b001, 32'h0000BEEF, 1'b0, 32'h0,       4'b0100, 3, 0, 1'b0);
      run(32'h00000000, 32'h00000001, 1'b1, 1'b0, 3'b001, 32'h0,        1'b1, 32'h0,       4'b0000, 2, 0, 1'b0);
      run(32'h10000000, 32'h00000002, 1'b1, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0,       4'b0000, 2, 0, 1'b0);
      run(32'h20000000, 32'h00000000, 1'b1, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0,       4'b0000, 2, 0, 1'b0);
      run(32'h00000000, 32'h00000000, 1'b1, 1'b1, 3'b010, 32'h0,        1'b1, 32'h0,       4'b0000, 2, 0, 1'b0);
      run(32'hFFFFFFFC, 32'h00000008, 1'b1, 1'b0, 3'b010, 32'h0,        1'b0, RAM_D,       4'b0001, 3, 0, 1'b0);
      run(32'h40000000, 32'h00000000, 1'b1, 1'b0, 3'b010, 32'h0,        1'b0, MC_D,        4'b1000, 7, 5, 1'b0);
      run(32'h40000010, 32'h00000000, 1'b1, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0,       4'b1000, 10, 0, 1'b0);
      run(32'h40000000, 32'h00000004, 1'b0, 1'b1, 3'b010, 32'h00C0FFEE, 1'b0, 32'h0,       4'b1000, 4, 2, 1'b0);
      run(32'h08000000, 32'h00000003, 1'b1, 1'b0, 3'b000, 32'h0,        1'b0, ROM_D,       4'b0010, 3, 0, 1'b1);

      // init with neither re nor wr is ignored
      @(posedge clk); #1;
      init = 1'b1; base = 32'h0; off = 32'h0; funct3 = 3'b010;
      @(posedge clk); #1;
      init = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("noop_init_quiet", 32'({s_re, s_wr, s_sel, done}), 32'd0);
      end

      // asynchronous reset while waiting on the multi-cycle slave
      mc_dly = 0;
      issue(32'h40000000, 32'h00000020, 1'b1, 1'b0, 3'b010, 32'h0);
      @(posedge clk); #4;
      rst_n = 1'b0;
      #1;
      chk("rst_wait_ctrl", 32'({done, err, s_sel, s_re, s_wr, s_funct3}), 32'd0);
      chk("rst_wait_rdata", rdata, 32'd0);
      chk("rst_wait_s_addr", s_addr, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'({s_re, s_wr, s_sel, done}), 32'd0);
      end

      run(32'h00000200, 32'h00000000, 1'b1, 1'b0, 3'b010, 32'h0,        1'b0, RAM_D,       4'b0001, 3, 0, 1'b0);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
